// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles every handshake/bus signal around the shared execute-stage ALU:
//   the two request ports, the combinational ALU hookup and the registered
//   response. clk/rst_n are not part of the bundle.
//
//   slave  modport : the arbiter (consumes requests and alu_result, drives
//                    readys, ALU control/operands and responses)
//   master modport : the environment (requesters plus the ALU itself)
//
//   Signals
//     req0_valid/ready, req0_op[3:0], req0_a/b[31:0]  port 0 (pipeline EX)
//     req1_valid/ready, req1_op[3:0], req1_a/b[31:0]  port 1 (aux unit)
//     req1_lock                                       port 1 keep-grant
//     alu_ctrl[3:0], alu_a/b[31:0]                    to ALU
//     alu_result[31:0]                                from ALU (combinational)
//     rsp0_valid, rsp1_valid, rsp_data[31:0], rsp_err response

interface alu_share_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_lock;

  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b, req1_lock,
    input  alu_result,
    output req0_ready, req1_ready,
    output alu_ctrl, alu_a, alu_b,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b, req1_lock,
    output alu_result,
    input  req0_ready, req1_ready,
    input  alu_ctrl, alu_a, alu_b,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares the single execute-stage ALU between port 0 (main pipeline EX)
//   and port 1 (auxiliary multi-cycle unit). One request is granted per
//   cycle, its op/operands drive the combinational ALU, and the result is
//   registered and returned to the winner exactly one cycle later.
//   Port 1 may lock the ALU for back-to-back sequences, bounded by MAX_LOCK.
//
//   Parameters
//     MAX_WAIT (1..15)  cycles port 1 may be denied before a forced grant
//     MAX_LOCK (1..255) max consecutive LOCK1 cycles for port 1
//
//   Ports
//     clk    clock
//     rst_n  synchronous active-low reset
//     bus    alu_share_arbiter_if.slave (requests, ALU drive, responses)
//
//   Build option
//     ALU_ARB_RR_EN  defined: round-robin arbitration in ARB (last_grant bit)
//                    undefined: port 0 priority with port 1 starvation counter

module alu_share_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_share_arbiter_if.slave        bus
);

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);
  localparam logic [3:0] OP_ADD   = 4'b0010;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_LOCK1 = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        force0_q, force0_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef ALU_ARB_RR_EN
  logic        last_grant_q, last_grant_d;   // 1 = port 1 granted last
`else
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  logic [3:0]  wait_cnt_q, wait_cnt_d;
`endif

  logic        grant0;
  logic        grant1;
  logic [3:0]  alu_ctrl_c;
  logic [31:0] alu_a_c;
  logic [31:0] alu_b_c;
  logic        op_legal;

  // Grant selection. Everything is gated by rst_n so that readys stay low
  // and the ALU sees idle values while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (state_q == ST_LOCK1) begin
        grant1 = bus.req1_valid;
      end else if (force0_q && bus.req0_valid) begin
        // Port 0 gets the first slot after a lock was cut short.
        grant0 = 1'b1;
`ifdef ALU_ARB_RR_EN
      end else if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else if (bus.req0_valid) begin
        grant0 = 1'b1;
`else
      end else if (bus.req0_valid &&
                   !(bus.req1_valid && (wait_cnt_q == WAIT_MAX))) begin
        grant0 = 1'b1;
`endif
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // ALU drive follows the winner; idle is ADD 0+0. Illegal codes pass
  // through untouched, only the returned result is masked.
  always_comb begin
    alu_ctrl_c = OP_ADD;
    alu_a_c    = 32'd0;
    alu_b_c    = 32'd0;
    if (grant0) begin
      alu_ctrl_c = bus.req0_op;
      alu_a_c    = bus.req0_a;
      alu_b_c    = bus.req0_b;
    end else if (grant1) begin
      alu_ctrl_c = bus.req1_op;
      alu_a_c    = bus.req1_a;
      alu_b_c    = bus.req1_b;
    end
  end

  always_comb begin
    case (alu_ctrl_c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b1000, 4'b1001, 4'b1010: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  end

  // Next-state logic for the lock FSM, starvation/lock counters and the
  // registered response.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    force0_d     = force0_q;
    rsp0_valid_d = grant0;
    rsp1_valid_d = grant1;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_ARB: begin
        force0_d = 1'b0;
        if (grant1 && bus.req1_lock) begin
          state_d    = ST_LOCK1;
          lock_cnt_d = 8'd1;
        end
      end
      ST_LOCK1: begin
        // Counts lock cycles, not grants: an idle lock cycle still uses
        // up the budget.
        lock_cnt_d = lock_cnt_q + 8'd1;
        if (lock_cnt_q == LOCK_MAX) begin
          state_d  = ST_ARB;
          force0_d = 1'b1;
        end else if (!bus.req1_lock) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (grant0 || grant1) begin
      rsp_data_d = op_legal ? bus.alu_result : 32'd0;
      rsp_err_d  = ~op_legal;
    end
  end

`ifdef ALU_ARB_RR_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant1)      last_grant_d = 1'b1;
    else if (grant0) last_grant_d = 1'b0;
  end
`else
  // Starvation counter: only meaningful while port 1 keeps asking.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.req1_valid || grant1)  wait_cnt_d = 4'd0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 4'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      lock_cnt_q   <= 8'd0;
      force0_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= 1'b0;
`else
      wait_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      force0_q     <= force0_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= last_grant_d;
`else
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.alu_ctrl   = alu_ctrl_c;
  assign bus.alu_a      = alu_a_c;
  assign bus.alu_b      = alu_b_c;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule
